// File: rtl/serial_add_sub.sv
// serial_add_sub: add/subtract two WIDTH-bit operands over WIDTH/BITS_PER_CYCLE
// cycles. Subtraction is done as a + ~b + 1, with the +1 supplied as the
// initial carry. Results appear on sum/cout/ovf/zero only when an operation
// completes and are held until the next one completes.
//
// state | meaning
// IDLE  | waiting for start; operands and mode captured on the accepting edge
// RUN   | one BITS_PER_CYCLE slice added per edge, LSB slice first
// DONE  | single-cycle done pulse; result registers already updated
module serial_add_sub #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int BPC = (BITS_PER_CYCLE < 1) ? 1 : BITS_PER_CYCLE;
    localparam int N   = WIDTH / BPC;
    localparam int CW  = $clog2(N + 1);

    generate
        if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
            $error("serial_add_sub: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [BPC:0]     slice;
    logic [WIDTH-1:0] slice_ext;
    logic [WIDTH-1:0] acc_nxt;
    logic             msb_cin;
    logic             last;

    // Slice adder and the shift-in of its result at the top of the accumulator.
    always_comb begin
        slice     = {1'b0, op_a[BPC-1:0]} + {1'b0, op_b[BPC-1:0]} + {{BPC{1'b0}}, carry};
        slice_ext = WIDTH'(slice[BPC-1:0]);
        acc_nxt   = (acc >> BPC) | (slice_ext << (WIDTH - BPC));
        // sum bit = a ^ b ^ cin, so the carry into the top bit of the slice
        // falls out of the slice sum; on the last slice that top bit is the MSB.
        msb_cin   = op_a[BPC-1] ^ op_b[BPC-1] ^ slice[BPC-1];
        last      = (cnt == CW'(N - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-slice datapath, and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> BPC;
                    op_b  <= op_b >> BPC;
                    acc   <= acc_nxt;
                    carry <= slice[BPC];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum  <= acc_nxt;
                        cout <= slice[BPC];
                        ovf  <= msb_cin ^ slice[BPC];
                        zero <= (acc_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three instances (8/1, 8/4, 16/2), expected results
// queued at issue time and popped when done pulses.
module tb_serial_add_sub;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          t0;
    } exp_t;

    localparam int N8  = 8;
    localparam int N4  = 2;
    localparam int N16 = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Edge counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    logic        st8 = 0, sb8 = 0, busy8, done8, cout8, ovf8, zero8;
    logic [7:0]  a8 = 0, b8 = 0, sum8;
    logic        st4 = 0, sb4 = 0, busy4, done4, cout4, ovf4, zero4;
    logic [7:0]  a4 = 0, b4 = 0, sum4;
    logic        st16 = 0, sb16 = 0, busy16, done16, cout16, ovf16, zero16;
    logic [15:0] a16 = 0, b16 = 0, sum16;

    serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8));

    serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .sub(sb4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4));

    serial_add_sub #(.WIDTH(16), .BITS_PER_CYCLE(2)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .sub(sb16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16));

    exp_t q8[$];
    exp_t q4[$];
    exp_t q16[$];
    int   ndone8 = 0;
    logic [15:0] prev8 = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o, input logic z);
        exp_t m;
        m.sum = s; m.cout = c; m.ovf = o; m.zero = z; m.t0 = 0;
        return m;
    endfunction

    // Whole-word reference: a + (b ^ mask(sub)) + sub, signed overflow from operand signs.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t m;
        logic [16:0] mask, aa, bb, r;
        mask   = (17'd1 << w) - 17'd1;
        aa     = {1'b0, a} & mask;
        bb     = ({1'b0, b} ^ (s ? mask : 17'd0)) & mask;
        r      = aa + bb + {16'd0, s};
        m.sum  = r[15:0] & mask[15:0];
        m.cout = r[w];
        m.ovf  = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        m.zero = (m.sum == 16'd0);
        m.t0   = 0;
        return m;
    endfunction

    task automatic check_out(input string tag, input logic [15:0] s, input logic c, input logic o,
                             input logic z, input exp_t e, input int n);
        chk({tag, "_sum"},  32'(s), 32'(e.sum));
        chk({tag, "_cout"}, 32'(c), 32'(e.cout));
        chk({tag, "_ovf"},  32'(o), 32'(e.ovf));
        chk({tag, "_zero"}, 32'(z), 32'(e.zero));
        chk({tag, "_lat"},  32'(cyc - e.t0), 32'(n));
    endtask

    // Scoreboard pop for each instance on its done pulse.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (done8) begin
            ndone8++;
            if (q8.size() == 0) chk("done8_unexpected", 32'(done8), 32'd0);
            else begin
                e = q8.pop_front();
                check_out("r8", {8'd0, sum8}, cout8, ovf8, zero8, e, N8);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (done4) begin
            if (q4.size() == 0) chk("done4_unexpected", 32'(done4), 32'd0);
            else begin
                e = q4.pop_front();
                check_out("r4", {8'd0, sum4}, cout4, ovf4, zero4, e, N4);
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (done16) begin
            if (q16.size() == 0) chk("done16_unexpected", 32'(done16), 32'd0);
            else begin
                e = q16.pop_front();
                check_out("r16", sum16, cout16, ovf16, zero16, e, N16);
            end
        end
    end

    function automatic logic busy_of(input int u);
        case (u)
            0:       return busy8;
            1:       return busy4;
            default: return busy16;
        endcase
    endfunction

    // Wait for idle, pulse start for one edge, queue the expectation, then scramble inputs.
    task automatic issue(input int u, input logic [15:0] a, input logic [15:0] b, input logic s,
                         input exp_t e);
        exp_t ee;
        int   k;
        ee = e;
        k  = 0;
        @(negedge clk);
        while (busy_of(u) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("idle_timeout", 32'(busy_of(u)), 32'd0);
        case (u)
            0:       begin st8  = 1; a8  = a[7:0]; b8  = b[7:0]; sb8  = s; end
            1:       begin st4  = 1; a4  = a[7:0]; b4  = b[7:0]; sb4  = s; end
            default: begin st16 = 1; a16 = a;      b16 = b;      sb16 = s; end
        endcase
        @(posedge clk);
        #1;
        ee.t0 = cyc;
        case (u)
            0: begin
                q8.push_back(ee);
                st8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sb8 = 1'($urandom);
            end
            1: begin
                q4.push_back(ee);
                st4 = 0; a4 = 8'($urandom); b4 = 8'($urandom); sb4 = 1'($urandom);
            end
            default: begin
                q16.push_back(ee);
                st16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); sb16 = 1'($urandom);
            end
        endcase
    endtask

    // 8-bit op with a mid-RUN look at busy and the held previous result.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input exp_t e);
        issue(0, {8'd0, a}, {8'd0, b}, s, e);
        repeat (3) @(negedge clk);
        chk("busy8_run", 32'(busy8), 32'd1);
        chk("hold_sum8", 32'(sum8), 32'(prev8));
        prev8 = e.sum;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q8.size() + q4.size() + q16.size()) != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_q8",  32'(q8.size()),  32'd0);
        chk("drain_q4",  32'(q4.size()),  32'd0);
        chk("drain_q16", 32'(q16.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        logic [15:0] ra, rb;
        logic        rs;
        int          nd0;

        // Reset state
        #12;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8",  32'(sum8),  32'd0);
        chk("rst_zero8", 32'(zero8), 32'd1);
        chk("rst_cout16", 32'(cout16), 32'd0);
        chk("rst_zero16", 32'(zero16), 32'd1);
        @(negedge clk);
        rst_n = 1;

        // Directed 8-bit, one bit per cycle
        run8(8'h7F, 8'h01, 1'b0, mk(16'h80, 0, 1, 0));
        run8(8'h05, 8'h07, 1'b1, mk(16'hFE, 0, 0, 0));
        run8(8'h80, 8'h01, 1'b1, mk(16'h7F, 1, 1, 0));
        run8(8'hFF, 8'h01, 1'b0, mk(16'h00, 1, 0, 1));
        run8(8'h00, 8'h01, 1'b1, mk(16'hFF, 0, 0, 0));
        run8(8'h40, 8'h40, 1'b1, mk(16'h00, 1, 0, 1));
        drain();

        // Directed 8-bit, four bits per cycle
        issue(1, 16'hFF, 16'h01, 1'b0, mk(16'h00, 1, 0, 1));
        issue(1, 16'h7F, 16'h01, 1'b0, mk(16'h80, 0, 1, 0));
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            issue(1, ra, rb, rs, model(8, ra, rb, rs));
        end
        issue(1, 16'h80, 16'h01, 1'b1, mk(16'h7F, 1, 1, 0));
        drain();

        // start held high with operands changing every cycle
        nd0 = ndone8;
        @(negedge clk);
        for (int k = 0; k < 4 * (N8 + 2); k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            st8 = 1; a8 = ra[7:0]; b8 = rb[7:0]; sb8 = rs;
            @(posedge clk);
            #1;
            if (k % (N8 + 2) == 0) begin
                exp_t e;
                e = model(8, ra, rb, rs);
                e.t0 = cyc;
                q8.push_back(e);
                prev8 = e.sum;
            end
            @(negedge clk);
        end
        st8 = 0;
        drain();
        chk("held_done_count", 32'(ndone8 - nd0), 32'd4);

        // Asynchronous reset in the middle of RUN
        issue(0, 16'h33, 16'h44, 1'b0, model(8, 16'h33, 16'h44, 1'b0));
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_busy8", 32'(busy8), 32'd0);
        chk("arst_done8", 32'(done8), 32'd0);
        chk("arst_sum8",  32'(sum8),  32'd0);
        chk("arst_cout8", 32'(cout8), 32'd0);
        chk("arst_ovf8",  32'(ovf8),  32'd0);
        chk("arst_zero8", 32'(zero8), 32'd1);
        chk("arst_sum4",  32'(sum4),  32'd0);
        chk("arst_zero4", 32'(zero4), 32'd1);
        q8.delete();
        prev8 = 16'd0;
        nd0 = ndone8;
        @(negedge clk);
        rst_n = 1;
        repeat (N8 + 4) @(negedge clk);
        chk("abort_no_done", 32'(ndone8 - nd0), 32'd0);

        // First start after reset release is accepted
        #1 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        issue(0, 16'h12, 16'h34, 1'b1, mk(16'hDE, 0, 0, 0));
        drain();

        // Random 16-bit, two bits per cycle, alternating modes
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'(i);
            if (i % 97 == 0) rb = ra;
            issue(2, ra, rb, rs, model(16, ra, rb, rs));
        end
        issue(2, 16'h7FFF, 16'hFFFF, 1'b1, mk(16'h8000, 0, 1, 0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
